// File: rtl/cpu_mem_arbiter.sv
// Two-requester (CPU, debug) arbiter in front of a single-port memory.
// Define CPU_MEM_ARB_DBG_PRIO_EN for fixed debug priority instead of round-robin.
module cpu_mem_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_addr,
  input  logic [15:0] i_cpu_wdata,
  output logic [15:0] o_cpu_rdata,
  output logic        o_cpu_ack,
  output logic        o_cpu_stall,
  input  logic        i_dbg_req,
  input  logic        i_dbg_we,
  input  logic [15:0] i_dbg_addr,
  input  logic [15:0] i_dbg_wdata,
  output logic [15:0] o_dbg_rdata,
  output logic        o_dbg_ack,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(MEM_LATENCY - 1);

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;  // 0 = CPU, 1 = debug
  logic        we_reg, we_next;
  logic [15:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic [1:0]  wait_cnt_reg, wait_cnt_next;
  logic        mem_en_reg, mem_we_reg;
  logic        any_req, grant_dbg;

  assign any_req = i_cpu_req | i_dbg_req;

`ifdef CPU_MEM_ARB_DBG_PRIO_EN
  assign grant_dbg = i_dbg_req;
`else
  logic last_dbg_reg;

  // On a tie the requester that did not win last time gets the grant.
  assign grant_dbg = i_dbg_req & (~i_cpu_req | ~last_dbg_reg);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_dbg_reg <= 1'b1;
    end else if (state_reg == IDLE && any_req) begin
      last_dbg_reg <= grant_dbg;
    end
  end
`endif

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
          owner_next = grant_dbg;
          we_next    = grant_dbg ? i_dbg_we    : i_cpu_we;
          addr_next  = grant_dbg ? i_dbg_addr  : i_cpu_addr;
          wdata_next = grant_dbg ? i_dbg_wdata : i_cpu_wdata;
        end
      end
      ACCESS: begin
        if (we_reg || MEM_LATENCY == 1) begin
          state_next = RESP;
        end else begin
          state_next    = WAIT;
          wait_cnt_next = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (wait_cnt_reg <= 2'd1) begin
          state_next    = RESP;
          wait_cnt_next = 2'd0;
        end else begin
          wait_cnt_next = wait_cnt_reg - 2'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wait_cnt_reg <= '0;
      mem_en_reg   <= 1'b0;
      mem_we_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_en_reg   <= (state_next == ACCESS);
      mem_we_reg   <= (state_next == ACCESS) & we_next;
    end
  end

  // Per-requester ack pulse and read-data holding register.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam logic PORT_ID = (gi == 1);
    logic        ack_reg;
    logic [15:0] rdata_reg;
    logic        resp_next;

    assign resp_next = (state_next == RESP) && (owner_reg == PORT_ID);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        ack_reg   <= 1'b0;
        rdata_reg <= '0;
      end else begin
        ack_reg <= resp_next;
        if (resp_next && !we_reg) begin
          rdata_reg <= i_mem_rdata;
        end
      end
    end
  end

  assign o_mem_en    = mem_en_reg;
  assign o_mem_we    = mem_we_reg;
  assign o_mem_addr  = addr_reg;
  assign o_mem_wdata = wdata_reg;
  assign o_cpu_ack   = g_port[0].ack_reg;
  assign o_cpu_rdata = g_port[0].rdata_reg;
  assign o_dbg_ack   = g_port[1].ack_reg;
  assign o_dbg_rdata = g_port[1].rdata_reg;
  assign o_cpu_stall = i_cpu_req & ~o_cpu_ack;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: transaction-level timing model, vector table,
// directed corner sequences and randomized traffic.
module tb_cpu_mem_arbiter;

  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (MEM_LATENCY = 1)
  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  // Second DUT (MEM_LATENCY = 3)
  logic        c3_req, c3_we, c3_ack, c3_stall;
  logic [15:0] c3_addr, c3_wdata, c3_rdata;
  logic        d3_req, d3_we, d3_ack;
  logic [15:0] d3_addr, d3_wdata, d3_rdata;
  logic        m3_en, m3_we;
  logic [15:0] m3_addr, m3_wdata, m3_rdata;

  logic [15:0] mem [256];
  assign mem_rdata = mem[mem_addr[7:0]];
  assign m3_rdata  = (m3_addr == 16'h0010) ? 16'hBEEF : 16'h0000;

  cpu_mem_arbiter #(.MEM_LATENCY(LAT)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack), .o_cpu_stall(cpu_stall),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_rdata(dbg_rdata), .o_dbg_ack(dbg_ack),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  cpu_mem_arbiter #(.MEM_LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(c3_req), .i_cpu_we(c3_we), .i_cpu_addr(c3_addr), .i_cpu_wdata(c3_wdata),
    .o_cpu_rdata(c3_rdata), .o_cpu_ack(c3_ack), .o_cpu_stall(c3_stall),
    .i_dbg_req(d3_req), .i_dbg_we(d3_we), .i_dbg_addr(d3_addr), .i_dbg_wdata(d3_wdata),
    .o_dbg_rdata(d3_rdata), .o_dbg_ack(d3_ack),
    .o_mem_en(m3_en), .o_mem_we(m3_we), .o_mem_addr(m3_addr), .o_mem_wdata(m3_wdata),
    .i_mem_rdata(m3_rdata)
  );

  typedef struct packed {
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } rq_t;

  typedef struct packed {
    logic        p;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic [3:0]  exp_lat;
  } vec_t;

  rq_t  rq [2];
  vec_t vecs [7];

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;
  int t = 0;

  // Transaction-level reference model
  bit          m_valid, m_owner, m_we, m_last_dbg;
  logic [15:0] m_addr, m_wdata, m_exp_rdata;
  int          m_grant_t, m_ack_t, free_t;
  logic [15:0] m_rdata [2];
  logic [15:0] model_mem [256];
  bit          ack_prev [2];
  bit          pending [2];

  bit          wr_pend;
  logic [7:0]  wr_a;
  logic [15:0] wr_d;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %b expected %b", name, t, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  task automatic drive();
    cpu_req = rq[0].req; cpu_we = rq[0].we; cpu_addr = rq[0].addr; cpu_wdata = rq[0].wdata;
    dbg_req = rq[1].req; dbg_we = rq[1].we; dbg_addr = rq[1].addr; dbg_wdata = rq[1].wdata;
  endtask

  task automatic cyc_begin();
    bit ea [2];
    bit exp_en;
    bit w;
    drive();
    #1;
    exp_en = m_valid && (t == m_grant_t + 1);
    chk1("mem_en", mem_en, exp_en);
    chk1("mem_we", mem_we, exp_en && m_we);
    if (exp_en) begin
      chk16("mem_addr", mem_addr, m_addr);
      chk16("mem_wdata", mem_wdata, m_wdata);
    end
    for (int p = 0; p < 2; p++) begin
      ea[p] = m_valid && (t == m_ack_t) && (m_owner == p[0]);
      if (ea[p] && !m_we) m_rdata[p] = m_exp_rdata;
      ack_prev[p] = ea[p];
    end
    chk1("cpu_ack", cpu_ack, ea[0]);
    chk1("dbg_ack", dbg_ack, ea[1]);
    chk16("cpu_rdata", cpu_rdata, m_rdata[0]);
    chk16("dbg_rdata", dbg_rdata, m_rdata[1]);
    chk1("cpu_stall", cpu_stall, rq[0].req & ~ea[0]);
    if (m_valid && t == m_ack_t) begin
      n_txn++;
      $display("txn %0d: %s %s addr=%h data=%h grant@%0d ack@%0d", n_txn,
               m_owner ? "DBG" : "CPU", m_we ? "WR" : "RD", m_addr,
               m_we ? m_wdata : m_exp_rdata, m_grant_t, t);
      m_valid = 0;
    end
    if (t >= free_t && (rq[0].req || rq[1].req)) begin
`ifdef CPU_MEM_ARB_DBG_PRIO_EN
      w = rq[1].req;
`else
      w = (rq[0].req && rq[1].req) ? !m_last_dbg : rq[1].req;
      m_last_dbg = w;
`endif
      m_valid   = 1;
      m_owner   = w;
      m_we      = rq[w].we;
      m_addr    = rq[w].addr;
      m_wdata   = rq[w].wdata;
      m_grant_t = t;
      m_ack_t   = m_we ? t + 2 : t + 1 + LAT;
      free_t    = m_ack_t + 1;
      if (m_we) model_mem[m_addr[7:0]] = m_wdata;
      else      m_exp_rdata = model_mem[m_addr[7:0]];
    end
    wr_pend = mem_en && mem_we;
    wr_a    = mem_addr[7:0];
    wr_d    = mem_wdata;
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
    if (wr_pend) mem[wr_a] = wr_d;
    t++;
  endtask

  task automatic do_reset();
    rq[0].req = 0; rq[1].req = 0;
    drive();
    c3_req = 0; d3_req = 0;
    rst_n = 0;
    #1;
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk16("rst_mem_wdata", mem_wdata, 16'h0000);
    chk1("rst_cpu_ack", cpu_ack, 1'b0);
    chk1("rst_dbg_ack", dbg_ack, 1'b0);
    chk16("rst_cpu_rdata", cpu_rdata, 16'h0000);
    chk16("rst_dbg_rdata", dbg_rdata, 16'h0000);
    chk1("rst_cpu_stall", cpu_stall, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_valid = 0; free_t = 0; m_last_dbg = 1; m_grant_t = -10; m_ack_t = -10;
    m_rdata[0] = 0; m_rdata[1] = 0;
    ack_prev[0] = 0; ack_prev[1] = 0; pending[0] = 0; pending[1] = 0;
    t = 0;
    rst_n = 1;
  endtask

  initial begin
    int   c, lat, n_en, n_ack, ack_c;
    bit   got;
    logic [15:0] got_rd;
    bit   e_en, e_cack, e_dack;
    logic [15:0] e_addr;

    vecs[0] = '{1'b0, 1'b1, 16'h0001, 16'h1111, 16'h0000, 4'd2};
    vecs[1] = '{1'b1, 1'b1, 16'h0002, 16'h2222, 16'h0000, 4'd2};
    vecs[2] = '{1'b0, 1'b0, 16'h0002, 16'h0000, 16'h2222, 4'd2};
    vecs[3] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h1111, 4'd2};
    vecs[4] = '{1'b0, 1'b1, 16'h00FF, 16'hFFFF, 16'h0000, 4'd2};
    vecs[5] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'hFFFF, 4'd2};
    vecs[6] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'hA503, 4'd2};

    for (int i = 0; i < 256; i++) begin
      mem[i]       = 16'(i) ^ 16'hA500;
      model_mem[i] = 16'(i) ^ 16'hA500;
    end
    rq[0] = '0; rq[1] = '0;
    c3_we = 0; c3_addr = 0; c3_wdata = 0;
    d3_we = 0; d3_addr = 0; d3_wdata = 0;
    do_reset();

    // CPU write 0x0010 <- 0xBEEF
    rq[0] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF};
    for (c = 0; c < 4; c++) begin
      cyc_begin();
      if (c < 2) chk1("wr_stall", cpu_stall, 1'b1);
      if (c == 1) begin
        chk1("wr_en", mem_en, 1'b1);
        chk1("wr_we", mem_we, 1'b1);
        chk16("wr_addr", mem_addr, 16'h0010);
        chk16("wr_data", mem_wdata, 16'hBEEF);
      end
      chk1("wr_ack", cpu_ack, c == 2);
      cyc_end();
      if (c == 2) rq[0].req = 0;
    end

    // Vector table: one transaction per record from IDLE
    for (int v = 0; v < 7; v++) begin
      rq[vecs[v].p] = '{1'b1, vecs[v].we, vecs[v].addr, vecs[v].wdata};
      c = 0; got = 0; got_rd = 0;
      do begin
        cyc_begin();
        got = vecs[v].p ? dbg_ack : cpu_ack;
        got_rd = vecs[v].p ? dbg_rdata : cpu_rdata;
        cyc_end();
        c++;
      end while (!got && c < 10);
      lat = c - 1;
      chk16("vec_latency", 16'(lat), 16'(vecs[v].exp_lat));
      if (!vecs[v].we) chk16("vec_rdata", got_rd, vecs[v].exp_rdata);
      rq[vecs[v].p].req = 0;
    end

    // CPU req dropped during ACCESS: single issue, single ack
    rq[0] = '{1'b1, 1'b0, 16'h0005, 16'h0000};
    n_en = 0; n_ack = 0; ack_c = -1;
    for (c = 0; c < 7; c++) begin
      if (c == 1) rq[0].req = 0;
      cyc_begin();
      if (mem_en) n_en++;
      if (cpu_ack) begin n_ack++; ack_c = c; end
      cyc_end();
    end
    chk16("drop_access_cnt", 16'(n_en), 16'd1);
    chk16("drop_ack_cnt", 16'(n_ack), 16'd1);
    chk16("drop_ack_cycle", 16'(ack_c), 16'd2);

    // MEM_LATENCY=3 read of 0x0010
    c3_req = 1; c3_we = 0; c3_addr = 16'h0010;
    for (c = 0; c < 7; c++) begin
      cyc_begin();
      chk1("rd3_en", m3_en, c == 1);
      chk1("rd3_ack", c3_ack, c == 4);
      chk1("rd3_dbg_ack", d3_ack, 1'b0);
      chk1("rd3_stall", c3_stall, c < 4);
      if (c >= 4) chk16("rd3_rdata", c3_rdata, 16'hBEEF);
      if (c == 1) chk16("rd3_addr", m3_addr, 16'h0010);
      cyc_end();
      if (c == 4) c3_req = 0;
    end

    // Reset pulsed during WAIT of a read
    c3_req = 1; c3_we = 0; c3_addr = 16'h0010;
    for (c = 0; c < 3; c++) begin
      cyc_begin();
      if (c < 2) cyc_end();
    end
    c3_req = 0;
    rst_n = 0;
    #1;
    chk1("ab_en", m3_en, 1'b0);
    chk1("ab_we", m3_we, 1'b0);
    chk16("ab_addr", m3_addr, 16'h0000);
    chk16("ab_wdata", m3_wdata, 16'h0000);
    chk1("ab_cpu_ack", c3_ack, 1'b0);
    chk1("ab_dbg_ack", d3_ack, 1'b0);
    chk16("ab_cpu_rdata", c3_rdata, 16'h0000);
    chk16("ab_dbg_rdata", d3_rdata, 16'h0000);
    chk1("ab_stall", c3_stall, 1'b0);
    do_reset();
    c3_req = 1; c3_we = 1; c3_addr = 16'h0044; c3_wdata = 16'h1234;
    for (c = 0; c < 5; c++) begin
      cyc_begin();
      chk1("ab_next_en", m3_en, c == 1);
      chk1("ab_next_we", m3_we, c == 1);
      chk1("ab_next_ack", c3_ack, c == 2);
      if (c == 1) begin
        chk16("ab_next_addr", m3_addr, 16'h0044);
        chk16("ab_next_wdata", m3_wdata, 16'h1234);
      end
      if (c == 4) chk16("ab_rdata_hold", c3_rdata, 16'h0000);
      cyc_end();
      if (c == 2) c3_req = 0;
    end

    // Both requesters reading continuously
    do_reset();
    rq[0] = '{1'b1, 1'b0, 16'h0020, 16'h0000};
    rq[1] = '{1'b1, 1'b0, 16'h0030, 16'h0000};
    for (c = 0; c < 12; c++) begin
      cyc_begin();
      e_en = (c % 3 == 1);
`ifdef CPU_MEM_ARB_DBG_PRIO_EN
      e_addr = 16'h0030;
      e_cack = 0;
      e_dack = (c % 3 == 2);
`else
      e_addr = ((c / 3) % 2 == 0) ? 16'h0020 : 16'h0030;
      e_cack = (c == 2 || c == 8);
      e_dack = (c == 5 || c == 11);
`endif
      chk1("rr_en", mem_en, e_en);
      if (e_en) chk16("rr_grant_addr", mem_addr, e_addr);
      chk1("rr_cpu_ack", cpu_ack, e_cack);
      chk1("rr_dbg_ack", dbg_ack, e_dack);
      chk1("rr_cpu_stall", cpu_stall, !e_cack);
      cyc_end();
    end
    rq[0].req = 0; rq[1].req = 0;
    for (c = 0; c < 4; c++) begin
      cyc_begin();
      cyc_end();
    end

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (ack_prev[p]) pending[p] = 0;
        if (!pending[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            pending[p]   = 1;
            rq[p].req    = 1;
            rq[p].we     = 1'($urandom_range(0, 1));
            rq[p].addr   = 16'($urandom_range(0, 15));
            rq[p].wdata  = 16'($urandom);
          end else begin
            rq[p].req  = 0;
            rq[p].addr = 16'($urandom);
          end
        end else if (m_valid && m_owner == p[0] && t == m_grant_t + 1 &&
                     $urandom_range(0, 5) == 0) begin
          rq[p].req = 0;
        end
      end
      cyc_begin();
      cyc_end();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
